// File: rtl/buf_if_pkg.sv
// Shared definitions for the buffer-interface SPI master.
// Holds word widths, request/response field positions, the handshake FSM
// state encoding and a helper that turns a request word into the SPI frame.
package buf_if_pkg;

  localparam int REQ_W      = 41;
  localparam int RSP_W      = 41;
  localparam int FRAME_BITS = 41;

  // Request word {adr[7:0], dat[31:0], rd}; response word {1'b0, rdata, 8'h00}
  localparam int REQ_RD_BIT  = 0;
  localparam int REQ_DAT_LSB = 1;
  localparam int REQ_ADR_LSB = 33;
  localparam int RSP_DAT_LSB = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_ACK,
    ST_GAP
  } state_t;

  // Serial order is rd, adr MSB first, dat MSB first. Reads send zeros in
  // the data field so the slave can drive MISO without bus contention.
  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [REQ_W-1:0] req);
    logic rd;
    rd = req[REQ_RD_BIT];
    return {rd, req[REQ_ADR_LSB +: 8], rd ? 32'h0 : req[REQ_DAT_LSB +: 32]};
  endfunction

endpackage

// File: rtl/buf_spi_master_if.sv
// Request/acknowledge buffer interface between the Wishbone front end
// (master) and the SPI master (slave).
//   REQ_VALID_I  request valid level
//   REQ_DATA_I   request word {adr, dat, rd}
//   RSP_ACK_O    request done
//   RSP_DATA_O   response word {1'b0, rdata, 8'h00}
interface buf_spi_master_if;
  import buf_if_pkg::*;

  logic             REQ_VALID_I;
  logic [REQ_W-1:0] REQ_DATA_I;
  logic             RSP_ACK_O;
  logic [RSP_W-1:0] RSP_DATA_O;

  modport master (output REQ_VALID_I, REQ_DATA_I, input RSP_ACK_O, RSP_DATA_O);
  modport slave  (input REQ_VALID_I, REQ_DATA_I, output RSP_ACK_O, RSP_DATA_O);
endinterface

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: SCLK divider, half-period counter, MOSI shift
// register and MISO capture for one 41-bit frame.
//   clk, rst      clock, async active-high reset
//   start         load frame_word/rd and begin a frame (one-cycle pulse)
//   frame_word    frame bits, MSB sent first
//   rd            frame is a read: capture MISO on the last 32 rising edges
//   miso          serial data in
//   sclk, mosi    registered SPI outputs
//   rdata         captured read data (0 for writes)
//   setup_end     last cycle of the setup half-period
//   shift_end     last cycle of the final SCLK high phase
//   done          last cycle of the hold half-period
// A frame is 84 half-periods of CLK_DIV cycles: half 0 is setup, halves
// 1..82 alternate low/high for the 41 bits, half 83 is hold.
module spi_bit_engine import buf_if_pkg::*; #(
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame_word,
  input  logic                  rd,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic [31:0]           rdata,
  output logic                  setup_end,
  output logic                  shift_end,
  output logic                  done
);
  localparam int LAST_HALF = 2 * FRAME_BITS + 1;
  // Half-period ending just before the high phase of the first data bit
  localparam int FIRST_RD_HALF = 2 * (FRAME_BITS - 32) + 1;

  logic                  busy;
  logic                  rd_q;
  logic [7:0]            div_cnt;
  logic [6:0]            half;
  logic [FRAME_BITS-1:0] sh;
  logic                  half_end;

  assign half_end  = busy && (div_cnt == 8'(CLK_DIV - 1));
  assign setup_end = half_end && (half == 7'd0);
  assign shift_end = half_end && (half == 7'(LAST_HALF - 1));
  assign done      = half_end && (half == 7'(LAST_HALF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      rd_q    <= 1'b0;
      div_cnt <= '0;
      half    <= '0;
      sh      <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      rdata   <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      rd_q    <= rd;
      div_cnt <= '0;
      half    <= '0;
      sh      <= frame_word;
      sclk    <= 1'b0;
      mosi    <= frame_word[FRAME_BITS-1];
      rdata   <= '0;
    end else if (busy) begin
      div_cnt <= half_end ? 8'd0 : div_cnt + 8'd1;
      if (half_end) begin
        half <= half + 7'd1;
        if (done) begin
          busy <= 1'b0;
        end else if (half[0]) begin
          // Rising edge: slave and master both sample here
          sclk <= 1'b1;
          if (rd_q && half >= 7'(FIRST_RD_HALF))
            rdata <= {rdata[30:0], miso};
        end else if (half != 7'd0) begin
          // Falling edge: present the next bit (zeros after the last one)
          sclk <= 1'b0;
          mosi <= sh[FRAME_BITS-2];
          sh   <= {sh[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/buf_spi_master.sv
// Buffer-interface SPI master: accepts one request word over a four-phase
// valid/ack handshake, runs it as a single SPI frame and returns the
// response word with RSP_ACK_O.
//   WB_CLK_I, WB_RST_I   clock, async active-high reset
//   bus                  request/response buffer interface (slave side)
//   SPI_SCLK_O           SPI clock, mode 0
//   SPI_MOSI_O           serial data out
//   SPI_MISO_I           serial data in
//   SPI_CS_N_O           active-low chip select
module buf_spi_master import buf_if_pkg::*; #(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic            WB_CLK_I,
  input  logic            WB_RST_I,
  buf_spi_master_if.slave bus,
  output logic            SPI_SCLK_O,
  output logic            SPI_MOSI_O,
  input  logic            SPI_MISO_I,
  output logic            SPI_CS_N_O
);
  state_t           state;
  logic [7:0]       gap_cnt;
  logic             gap_ok;
  logic             accept;
  logic             cs_n_q;
  logic             ack_q;
  logic [RSP_W-1:0] rsp_q;
  logic [31:0]      rdata;
  logic             setup_end, shift_end, eng_done;

  // gap_cnt counts cycles since CS_N last rose and saturates at CS_GAP;
  // reset preloads it so the first request does not wait.
  assign gap_ok = (gap_cnt == 8'(CS_GAP));
  assign accept = (state == ST_IDLE) && bus.REQ_VALID_I && !ack_q && gap_ok;

  spi_bit_engine #(.CLK_DIV(CLK_DIV)) u_eng (
    .clk        (WB_CLK_I),
    .rst        (WB_RST_I),
    .start      (accept),
    .frame_word (frame_of(bus.REQ_DATA_I)),
    .rd         (bus.REQ_DATA_I[REQ_RD_BIT]),
    .miso       (SPI_MISO_I),
    .sclk       (SPI_SCLK_O),
    .mosi       (SPI_MOSI_O),
    .rdata      (rdata),
    .setup_end  (setup_end),
    .shift_end  (shift_end),
    .done       (eng_done)
  );

  always_ff @(posedge WB_CLK_I or posedge WB_RST_I) begin
    if (WB_RST_I) begin
      state   <= ST_IDLE;
      gap_cnt <= 8'(CS_GAP);
      cs_n_q  <= 1'b1;
      ack_q   <= 1'b0;
      rsp_q   <= '0;
    end else begin
      if (eng_done)
        gap_cnt <= 8'd1;
      else if (!gap_ok)
        gap_cnt <= gap_cnt + 8'd1;

      case (state)
        ST_IDLE:  if (accept) begin
                    cs_n_q <= 1'b0;
                    state  <= ST_SETUP;
                  end
        ST_SETUP: if (setup_end) state <= ST_SHIFT;
        ST_SHIFT: if (shift_end) state <= ST_HOLD;
        ST_HOLD:  if (eng_done) begin
                    cs_n_q <= 1'b1;
                    ack_q  <= 1'b1;
                    rsp_q  <= {1'b0, rdata, 8'h00};
                    state  <= ST_ACK;
                  end
        // Ack holds until valid is seen low, so a level still high from
        // this request can never start another frame.
        ST_ACK:   if (!bus.REQ_VALID_I) begin
                    ack_q <= 1'b0;
                    state <= ST_GAP;
                  end
        ST_GAP:   if (gap_ok) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign SPI_CS_N_O     = cs_n_q;
  assign bus.RSP_ACK_O  = ack_q;
  assign bus.RSP_DATA_O = rsp_q;

endmodule

// File: tb/tb_buf_spi_master.sv
module tb_buf_spi_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk0, mosi0, cs0, miso0;
  logic sclk1, mosi1, cs1;
  logic sclk5, mosi5, cs5;

  buf_spi_master_if b0();
  buf_spi_master_if b1();
  buf_spi_master_if b5();

  buf_spi_master #(.CLK_DIV(2), .CS_GAP(2)) d0 (
    .WB_CLK_I(clk), .WB_RST_I(rst), .bus(b0.slave),
    .SPI_SCLK_O(sclk0), .SPI_MOSI_O(mosi0), .SPI_MISO_I(miso0), .SPI_CS_N_O(cs0));
  buf_spi_master #(.CLK_DIV(1), .CS_GAP(2)) d1 (
    .WB_CLK_I(clk), .WB_RST_I(rst), .bus(b1.slave),
    .SPI_SCLK_O(sclk1), .SPI_MOSI_O(mosi1), .SPI_MISO_I(1'b0), .SPI_CS_N_O(cs1));
  buf_spi_master #(.CLK_DIV(5), .CS_GAP(2)) d5 (
    .WB_CLK_I(clk), .WB_RST_I(rst), .bus(b5.slave),
    .SPI_SCLK_O(sclk5), .SPI_MOSI_O(mosi5), .SPI_MISO_I(1'b0), .SPI_CS_N_O(cs5));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [40:0] exp_rsp_q[$];
  logic [40:0] exp_frm_q[$];
  logic [31:0] slave_data = 32'h0;
  int rise_cnt = 0, cs_low_cnt = 0, cs_high_cnt = 0;
  logic [40:0] mosi_cap = '0;
  bit   have_prev = 1'b0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0, prev_ack = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // SPI slave: shifts out slave_data MSB first during the 32 data bits,
  // changing only while SCLK is low.
  always_comb begin
    miso0 = 1'b0;
    if (rise_cnt >= 9 && rise_cnt <= 40) miso0 = slave_data[5'(40 - rise_cnt)];
  end

  // Monitor: frame shape, MOSI content, gap, and response scoreboard
  initial forever begin
    @(negedge clk);
    if (rst) begin
      rise_cnt = 0; cs_low_cnt = 0; cs_high_cnt = 0; mosi_cap = '0;
      have_prev = 1'b0; prev_cs = 1'b1; prev_sclk = 1'b0; prev_ack = 1'b0;
    end else begin
      if (!cs0 && prev_cs) begin
        if (have_prev) check("cs_gap_min", 64'(cs_high_cnt >= 2), 1);
        cs_low_cnt = 0;
        mosi_cap = '0;
      end
      if (!cs0) cs_low_cnt++;
      if (sclk0 && !prev_sclk) begin
        mosi_cap = {mosi_cap[39:0], mosi0};
        rise_cnt++;
      end
      if (cs0 && !prev_cs) begin
        check("cs_low_cycles", cs_low_cnt, 168);
        check("sclk_rises", rise_cnt, 41);
        check("ack_with_cs_rise", b0.RSP_ACK_O, 1);
        check("frame_expected", 64'(exp_frm_q.size() > 0), 1);
        if (exp_frm_q.size() > 0) check("mosi_frame", mosi_cap, exp_frm_q.pop_front());
        cs_high_cnt = 0;
        rise_cnt = 0;
        have_prev = 1'b1;
      end
      if (cs0) cs_high_cnt++;
      if (b0.RSP_ACK_O && !prev_ack) begin
        check("rsp_expected", 64'(exp_rsp_q.size() > 0), 1);
        if (exp_rsp_q.size() > 0) check("rsp_data", b0.RSP_DATA_O, exp_rsp_q.pop_front());
      end
      prev_cs = cs0; prev_sclk = sclk0; prev_ack = b0.RSP_ACK_O;
    end
  end

  task automatic run_req(input logic [40:0] req, input logic [40:0] rsp, input logic [40:0] frm,
                         input logic [31:0] sd, input int hold, input int drop_bit);
    int n;
    int hi;
    @(negedge clk);
    slave_data = sd;
    exp_rsp_q.push_back(rsp);
    exp_frm_q.push_back(frm);
    b0.REQ_DATA_I = req;
    b0.REQ_VALID_I = 1'b1;
    if (drop_bit >= 0) begin
      n = 0;
      while (rise_cnt < drop_bit && n < 2000) begin @(negedge clk); n++; end
      b0.REQ_VALID_I = 1'b0;
      b0.REQ_DATA_I = ~req;
    end
    n = 0;
    while (!b0.RSP_ACK_O && n < 2000) begin @(negedge clk); n++; end
    check("ack_seen", 64'(n < 2000), 1);
    hi = 0;
    repeat (hold) begin @(negedge clk); if (b0.RSP_ACK_O) hi++; end
    if (hold > 0) check("ack_held", hi, hold);
    b0.REQ_VALID_I = 1'b0;
    @(negedge clk);
    check("ack_cleared", b0.RSP_ACK_O, 0);
  endtask

  // Frame length and SCLK phase widths for the CLK_DIV=1 / CLK_DIV=5 units
  task automatic meas(input int s, input int div);
    int lo = 0, hr = 0, lr = 0, n = 0, hi_len = -1, lo_len = -1;
    bit seen_hi = 1'b0;
    logic c, k, a;
    @(negedge clk);
    if (s == 0) begin b1.REQ_DATA_I = {8'h11, 32'h80000001, 1'b0}; b1.REQ_VALID_I = 1'b1; end
    else        begin b5.REQ_DATA_I = {8'h11, 32'h80000001, 1'b0}; b5.REQ_VALID_I = 1'b1; end
    do begin
      @(negedge clk);
      n++;
      c = (s == 0) ? cs1 : cs5;
      k = (s == 0) ? sclk1 : sclk5;
      a = (s == 0) ? b1.RSP_ACK_O : b5.RSP_ACK_O;
      if (!c) lo++;
      if (k) begin
        hr++;
        if (lr > 0 && seen_hi && lo_len < 0) lo_len = lr;
        lr = 0;
        seen_hi = 1'b1;
      end else begin
        if (hr > 0 && hi_len < 0) hi_len = hr;
        hr = 0;
        if (!c && seen_hi) lr++;
      end
    end while (!a && n < 2000);
    check("div_ack_seen", 64'(n < 2000), 1);
    check("div_cs_low", lo, 84 * div);
    check("div_sclk_high", hi_len, div);
    check("div_sclk_low", lo_len, div);
    b1.REQ_VALID_I = 1'b0;
    b5.REQ_VALID_I = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    b0.REQ_VALID_I = 1'b0; b0.REQ_DATA_I = '0;
    b1.REQ_VALID_I = 1'b0; b1.REQ_DATA_I = '0;
    b5.REQ_VALID_I = 1'b0; b5.REQ_DATA_I = '0;
    repeat (2) @(negedge clk);
    check("rst_cs_n", cs0, 1);
    check("rst_sclk", sclk0, 0);
    check("rst_mosi", mosi0, 0);
    check("rst_ack", b0.RSP_ACK_O, 0);
    check("rst_rsp", b0.RSP_DATA_O, 0);
    #2 rst = 1'b0;

    // Write: MISO driven all ones must not leak into the response
    run_req({8'hA5, 32'hDEADBEEF, 1'b0}, 41'h0, {1'b0, 8'hA5, 32'hDEADBEEF},
            32'hFFFFFFFF, 5, -1);
    // Read: data field of the request must not appear on MOSI
    run_req({8'h3C, 32'hFFFF0000, 1'b1}, {1'b0, 32'h12345678, 8'h00}, {1'b1, 8'h3C, 32'h0},
            32'h12345678, 0, -1);
    // Back-to-back write with valid dropped and data changed at bit 10
    run_req({8'h5A, 32'h0F0F1234, 1'b0}, 41'h0, {1'b0, 8'h5A, 32'h0F0F1234},
            32'hAAAAAAAA, 0, 10);

    // Reset mid-frame while SCLK is high and MOSI carries a 1
    @(negedge clk);
    b0.REQ_DATA_I = {8'h77, 32'hFFFFFFFF, 1'b0};
    b0.REQ_VALID_I = 1'b1;
    n = 0;
    while (rise_cnt < 20 && n < 2000) begin @(negedge clk); n++; end
    check("midrst_reached", 64'(n < 2000), 1);
    check("midrst_pre_sclk", sclk0, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_cs_n", cs0, 1);
    check("midrst_sclk", sclk0, 0);
    check("midrst_mosi", mosi0, 0);
    check("midrst_ack", b0.RSP_ACK_O, 0);
    b0.REQ_VALID_I = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    run_req({8'hC3, 32'hCAFEF00D, 1'b0}, 41'h0, {1'b0, 8'hC3, 32'hCAFEF00D},
            32'h55555555, 0, -1);

    meas(0, 1);
    meas(1, 5);

    check("rsp_queue_drained", exp_rsp_q.size(), 0);
    check("frm_queue_drained", exp_frm_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
